// File: rtl/npu_pkg.sv
// ---------------------------------------------------------------------------
// npu_pkg
// Shared definitions for the MAC/pool unit: controller state encoding,
// bit positions inside the finalize control byte (in0) and the requant
// configuration byte (in_param), and the default accumulator width.
// ---------------------------------------------------------------------------
package npu_pkg;

    // Controller states: waiting for a header, collecting taps, waiting for
    // the finalize beat, and streaming four unpooled bytes.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Finalize control byte (carried on in0)
    localparam int CTRL_RELU = 7;
    localparam int CTRL_POOL = 6;
    localparam int CTRL_OE   = 0;

    // Requant configuration byte (carried on in_param during finalize)
    localparam int CFG_SHIFT_MSB = 4;
    localparam int CFG_SHIFT_LSB = 0;
    localparam int CFG_ROUND     = 5;

    localparam int ACC_W_DEFAULT = 24;

endpackage

// File: rtl/npu_requant.sv
// ---------------------------------------------------------------------------
// npu_requant
// Purely combinational requantisation of one accumulator lane to one byte:
// optional round-half-up, arithmetic right shift, then clamp to an unsigned
// [0,255] range when ReLU is active or a signed [-128,127] range otherwise.
//
// Ports:
//   x_i      signed accumulator value (ACC_W bits)
//   shift_i  right-shift amount S (0..31)
//   round_i  add 2^(S-1) before shifting when S is non-zero
//   relu_i   selects the unsigned clamp range
//   y_o      resulting byte (two's complement when relu_i is low)
// ---------------------------------------------------------------------------
module npu_requant
    import npu_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic signed [ACC_W-1:0] x_i,
    input  logic        [4:0]       shift_i,
    input  logic                    round_i,
    input  logic                    relu_i,
    output logic        [7:0]       y_o
);

    // Working width leaves room for a rounding constant of up to 2^30 on top
    // of the full accumulator range, so large shifts never wrap.
    localparam int WW = ACC_W + 33;

    localparam logic signed [WW-1:0] U_MAX = 255;
    localparam logic signed [WW-1:0] S_MAX = 127;
    localparam logic signed [WW-1:0] S_MIN = -128;
    localparam logic signed [WW-1:0] ZERO  = 0;

    logic signed [WW-1:0] xWide;
    logic signed [WW-1:0] rndConst;
    logic signed [WW-1:0] sumWide;
    logic signed [WW-1:0] shifted;

    // Round, shift and saturate to the selected byte range.
    always_comb begin
        xWide    = {{33{x_i[ACC_W-1]}}, x_i};
        rndConst = '0;
        if (round_i && (shift_i != 5'd0)) begin
            rndConst = {{(WW-1){1'b0}}, 1'b1} << (shift_i - 5'd1);
        end
        sumWide = xWide + rndConst;
        shifted = sumWide >>> shift_i;
        y_o     = shifted[7:0];
        if (relu_i) begin
            if (shifted < ZERO) begin
                y_o = 8'h00;
            end else if (shifted > U_MAX) begin
                y_o = 8'hFF;
            end
        end else begin
            if (shifted < S_MIN) begin
                y_o = 8'h80;
            end else if (shifted > S_MAX) begin
                y_o = 8'h7F;
            end
        end
    end

endmodule

// File: rtl/npu_mac_pool_unit.sv
// ---------------------------------------------------------------------------
// npu_mac_pool_unit
// Four parallel MAC lanes (one per conv position of a 2x2 pool window)
// driven by a header / tap / finalize beat protocol. Finalize applies an
// optional ReLU and 2x2 max-pool, then requantises to bytes for write-back.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   in_valid        beat valid; a beat moves when in_valid && in_ready
//   in_ready        low only while four unpooled bytes are streamed out
//   in0..in3        pixel lanes (unsigned); in1 = tap count on header,
//                   in0 = control byte on finalize
//   in_param        bias (header), weight (tap) or requant config (finalize)
//   D_out           result byte, qualified by out_valid (one cycle per byte)
//   result_count    running count of emitted bytes (16-bit, wraps)
//   err             sticky flag: header requested more than MAX_TAPS taps
// ---------------------------------------------------------------------------
module npu_mac_pool_unit
    import npu_pkg::*;
#(
    parameter int ACC_W      = ACC_W_DEFAULT,
    parameter int BIAS_SHIFT = 8,
    parameter int MAX_TAPS   = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in0,
    input  logic [7:0]  in1,
    input  logic [7:0]  in2,
    input  logic [7:0]  in3,
    input  logic [7:0]  in_param,
    output logic [7:0]  D_out,
    output logic        out_valid,
    output logic [15:0] result_count,
    output logic        err
);

    state_e state_q, state_d;

    logic signed [ACC_W-1:0] acc_q [4];
    logic        [7:0]       tapcnt_q;
    logic                    err_q;

    // Finalize pipeline: F1 holds post-ReLU (or pooled) lanes plus the
    // requant config; pending_q counts bytes still to be emitted from F1.
    logic signed [ACC_W-1:0] f1Lane_q [4];
    logic        [4:0]       f1Shift_q;
    logic                    f1Round_q;
    logic                    f1Relu_q;
    logic        [2:0]       pending_q;
    logic        [1:0]       sel_q;

    logic [7:0]  dOut_q;
    logic        outValid_q;
    logic [15:0] resultCount_q;

    logic                    accept;
    logic                    finAccept;
    logic        [7:0]       laneIn   [4];
    logic signed [ACC_W-1:0] biasInit;
    logic signed [16:0]      prod     [4];
    logic signed [ACC_W:0]   sumWide  [4];
    logic signed [ACC_W-1:0] accNext  [4];
    logic signed [ACC_W-1:0] reluLane [4];
    logic signed [ACC_W-1:0] poolMax;
    logic        [7:0]       rqByte;

    assign laneIn[0] = in0;
    assign laneIn[1] = in1;
    assign laneIn[2] = in2;
    assign laneIn[3] = in3;

    assign accept    = in_valid && in_ready;
    assign finAccept = accept && (state_q == FINAL) && in0[CTRL_OE];

    assign biasInit = $signed({{(ACC_W-8){in_param[7]}}, in_param}) <<< BIAS_SHIFT;

    // Controller state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. DRAIN lasts until the last of the four unpooled
    // bytes is being registered, so in_ready is low for exactly 4 cycles.
    always_comb begin
        state_d  = state_q;
        in_ready = (state_q != DRAIN);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (in1 != 8'd0) ? ACCUM : FINAL;
                end
            end
            ACCUM: begin
                if (accept && (tapcnt_q == 8'd1)) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                if (accept) begin
                    state_d = (in0[CTRL_OE] && !in0[CTRL_POOL]) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (pending_q == 3'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-lane 9x9 signed multiply (pixel zero-extended) and saturating
    // accumulate; overflow is detected from the guard bit of the sum.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            prod[k]    = $signed({9'b0, laneIn[k]}) * $signed({{9{in_param[7]}}, in_param});
            sumWide[k] = {acc_q[k][ACC_W-1], acc_q[k]} + {{(ACC_W-16){prod[k][16]}}, prod[k]};
            if (sumWide[k][ACC_W] != sumWide[k][ACC_W-1]) begin
                accNext[k] = sumWide[k][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                               : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                accNext[k] = sumWide[k][ACC_W-1:0];
            end
        end
    end

    // Accumulators, tap counter and the sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                acc_q[k] <= '0;
            end
            tapcnt_q <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            if (state_q == IDLE) begin
                for (int k = 0; k < 4; k++) begin
                    acc_q[k] <= biasInit;
                end
                tapcnt_q <= in1;
                if (in1 > 8'(MAX_TAPS)) begin
                    err_q <= 1'b1;
                end
            end else if (state_q == ACCUM) begin
                for (int k = 0; k < 4; k++) begin
                    acc_q[k] <= accNext[k];
                end
                tapcnt_q <= tapcnt_q - 8'd1;
            end
        end
    end

    // ReLU per lane, then the signed maximum across the pool window.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            reluLane[k] = (in0[CTRL_RELU] && acc_q[k][ACC_W-1]) ? '0 : acc_q[k];
        end
        poolMax = reluLane[0];
        for (int k = 1; k < 4; k++) begin
            if (reluLane[k] > poolMax) begin
                poolMax = reluLane[k];
            end
        end
    end

    // F1 stage and drain sequencer. A pooled result occupies slot 0 and
    // emits one byte; otherwise all four lanes are walked in order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                f1Lane_q[k] <= '0;
            end
            f1Shift_q <= '0;
            f1Round_q <= 1'b0;
            f1Relu_q  <= 1'b0;
            pending_q <= '0;
            sel_q     <= '0;
        end else if (finAccept) begin
            f1Shift_q <= in_param[CFG_SHIFT_MSB:CFG_SHIFT_LSB];
            f1Round_q <= in_param[CFG_ROUND];
            f1Relu_q  <= in0[CTRL_RELU];
            sel_q     <= '0;
            if (in0[CTRL_POOL]) begin
                f1Lane_q[0] <= poolMax;
                pending_q   <= 3'd1;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    f1Lane_q[k] <= reluLane[k];
                end
                pending_q <= 3'd4;
            end
        end else if (pending_q != 3'd0) begin
            sel_q     <= sel_q + 2'd1;
            pending_q <= pending_q - 3'd1;
        end
    end

    npu_requant #(
        .ACC_W (ACC_W)
    ) u_requant (
        .x_i     (f1Lane_q[sel_q]),
        .shift_i (f1Shift_q),
        .round_i (f1Round_q),
        .relu_i  (f1Relu_q),
        .y_o     (rqByte)
    );

    // F2 output register; the byte counter advances with every valid byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dOut_q        <= '0;
            outValid_q    <= 1'b0;
            resultCount_q <= '0;
        end else begin
            outValid_q <= (pending_q != 3'd0);
            if (pending_q != 3'd0) begin
                dOut_q        <= rqByte;
                resultCount_q <= resultCount_q + 16'd1;
            end
        end
    end

    assign D_out        = dOut_q;
    assign out_valid    = outValid_q;
    assign result_count = resultCount_q;
    assign err          = err_q;

endmodule
